// File: rtl/voice_pkg.sv
// Shared defaults and FSM encodings for the voice burst writer.
package voice_pkg;

    localparam int unsigned DEF_DW     = 16;
    localparam int unsigned DEF_BURST  = 128;
    localparam int unsigned DEF_BAW    = 7;
    localparam int unsigned DEF_DROP_W = 8;

    typedef enum logic [1:0] {
        B_IDLE,
        B_PREP,
        B_BURST
    } burst_st_t;

    typedef enum logic {
        F_FILL,
        F_PAD
    } fill_st_t;

endpackage

// File: rtl/voice_pp_ram.sv
// Simple dual-port ping-pong RAM: one write port, one registered read port (latency 1).
module voice_pp_ram #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/voice_burst_writer.sv
// Collects sparse voice samples into a ping-pong RAM and replays each full half
// as a gap-free burst of BURST write strobes toward the SDRAM FIFO.
module voice_burst_writer
    import voice_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned BURST  = DEF_BURST,
    parameter int unsigned BAW    = DEF_BAW,
    parameter int unsigned DROP_W = DEF_DROP_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rec_en,
    input  logic              i_smp_vld,
    input  logic [DW-1:0]     i_smp_data,
    input  logic              i_flush,
    input  logic              i_cach_full,
    output logic              o_wr,
    output logic [DW-1:0]     o_wr_data,
    output logic              o_busy,
    output logic              o_ovf,
    output logic [DROP_W-1:0] o_drop_cnt,
    output logic [15:0]       o_burst_cnt
);

    localparam logic [BAW-1:0] LAST = BAW'(BURST - 1);

    fill_st_t       fst;
    burst_st_t      bst;
    logic [BAW-1:0] idx;
    logic [BAW-1:0] idx_nxt;
    logic           wh;
    logic           rh;
    logic [1:0]     rdy;
    logic [1:0]     rdy_set;
    logic [1:0]     rdy_clr;
    logic [BAW-1:0] rcnt;
    logic [BAW-1:0] bcnt;
    logic           accept;
    logic           wr_smp;
    logic           drop;
    logic           we;
    logic           idx_wrap;
    logic           start;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rd_data;

    always_comb begin
        accept  = i_smp_vld & i_rec_en;
        // A half whose last word is being emitted this cycle counts as drained,
        // so a continuous sample stream never loses the first word of the next pass.
        wr_smp  = accept & (fst == F_FILL) & ~(rdy[wh] & ~rdy_clr[wh]);
        drop    = accept & ~wr_smp;
        we      = wr_smp | (fst == F_PAD);
        wdata   = (fst == F_PAD) ? '0 : i_smp_data;
        idx_wrap = we & (idx == LAST);
        idx_nxt = wr_smp ? idx + BAW'(1) : idx;
        rdy_set = '0;
        if (idx_wrap)
            rdy_set[wh] = 1'b1;
        rdy_clr = '0;
        if (bst == B_BURST && bcnt == LAST)
            rdy_clr[rh] = 1'b1;
        // Completion is seen the same cycle it happens to meet the k+2 strobe latency.
        start   = (bst == B_IDLE) & (rdy[rh] | rdy_set[rh]) & ~i_cach_full;
    end

    assign o_busy = (bst != B_IDLE);

    voice_pp_ram #(
        .DW (DW),
        .AW (BAW + 1)
    ) u_ram (
        .clk   (i_clk),
        .we    (we),
        .waddr ({wh, idx}),
        .wdata (wdata),
        .raddr ({rh, rcnt}),
        .rdata (rd_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fst        <= F_FILL;
            idx        <= '0;
            wh         <= 1'b0;
            o_ovf      <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (we)
                idx <= idx + BAW'(1);
            if (idx_wrap)
                wh <= ~wh;
            case (fst)
                F_FILL: if (i_flush && idx_nxt != '0) fst <= F_PAD;
                F_PAD:  if (idx_wrap) fst <= F_FILL;
                default: fst <= F_FILL;
            endcase
            if (drop) begin
                o_ovf <= 1'b1;
                if (o_drop_cnt != '1)
                    o_drop_cnt <= o_drop_cnt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            rdy <= '0;
        else
            rdy <= (rdy | rdy_set) & ~rdy_clr;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bst         <= B_IDLE;
            rh          <= 1'b0;
            rcnt        <= '0;
            bcnt        <= '0;
            o_wr        <= 1'b0;
            o_wr_data   <= '0;
            o_burst_cnt <= '0;
        end else begin
            case (bst)
                B_IDLE: begin
                    if (start) begin
                        bst  <= B_PREP;
                        rcnt <= BAW'(1);
                    end
                end
                B_PREP: begin
                    bst       <= B_BURST;
                    rcnt      <= rcnt + BAW'(1);
                    bcnt      <= '0;
                    o_wr      <= 1'b1;
                    o_wr_data <= rd_data;
                end
                B_BURST: begin
                    rcnt      <= rcnt + BAW'(1);
                    bcnt      <= bcnt + BAW'(1);
                    o_wr_data <= rd_data;
                    if (bcnt == LAST) begin
                        bst         <= B_IDLE;
                        o_wr        <= 1'b0;
                        rh          <= ~rh;
                        rcnt        <= '0;
                        o_burst_cnt <= o_burst_cnt + 16'd1;
                    end
                end
                default: bst <= B_IDLE;
            endcase
        end
    end

endmodule
